tt_um_peak_tracker: RTL and testbench
=====================================

TT_UM_PEAK_TRACKER -- requirements
Module: tt_um_peak_tracker

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning the sample width in bits; only W=8 is supported on the pin map.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising edge active.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port ena, input, 1 bit: always 1 when powered; ignored.
REQ-005 The block SHALL have port ui_in, input, 8 bits: sample data, unsigned.
REQ-006 The block SHALL have port uio_in, input, 8 bits: [0] sample_valid; [1] clear; [3:2] win_sel; [7:4] unused.
REQ-007 The block SHALL have port uo_out, output, 8 bits: peak value.
REQ-008 The block SHALL have port uio_out, output, 8 bits: [3:0]=0; [4] done; [5] new_peak; [6] busy; [7]=0.
REQ-009 The block SHALL have port uio_oe, output, 8 bits: constant 8'hF0.

Function
REQ-010 A sample SHALL be accepted on a rising clk edge when sample_valid=1 and clear=0.
REQ-011 Comparison SHALL be unsigned over 8 bits; a tie SHALL NOT count as a new peak.
REQ-012 win_sel SHALL select the window length: 00 = free-running (no window); 01 = 4 samples; 10 = 16 samples; 11 = 64 samples.
REQ-013 The FSM SHALL have exactly two states, IDLE and TRACK.
REQ-014 In IDLE, an accepted sample SHALL load run_peak=sample, set count=1, latch win_sel into win_lat, and move to TRACK; if win_lat is 01/10/11, L=1 does not apply, so no window completes on the first sample.
REQ-015 In TRACK, an accepted sample SHALL set run_peak=max(run_peak,sample) and increment count.
REQ-016 In TRACK with win_lat≠00, when an accepted sample makes count equal L, the block SHALL load result=max(run_peak,sample), pulse done for one cycle, and return to IDLE.
REQ-017 With win_lat=00, the block SHALL stay in TRACK indefinitely, and count SHALL saturate at 63.
REQ-018 win_sel changes while in TRACK SHALL be ignored until the next IDLE→TRACK transition.
REQ-019 uo_out SHALL equal run_peak when win_lat=00, and result otherwise (in IDLE: result).
REQ-020 new_peak SHALL be a registered one-cycle pulse following any accepted sample that enters TRACK from IDLE or strictly exceeds run_peak.
REQ-021 busy SHALL be 1 exactly while in TRACK.
REQ-022 All outputs SHALL be registered: an effect of a sample accepted at edge k SHALL be visible after edge k and not before.
REQ-023 clear=1 SHALL take priority over sample_valid and SHALL, synchronously, set IDLE, run_peak=0, count=0, result=0, done=0, new_peak=0.
REQ-024 When sample_valid=0, state, counters and peaks SHALL hold, and done and new_peak SHALL be 0.
REQ-025 The path from ui_in and uio_in to the outputs SHALL contain no combinational path.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for clk, force: IDLE, run_peak=0, result=0, count=0, win_lat=00, uo_out=0, and uio_out=0.
REQ-027 Deassertion of rst_n SHALL be synchronized to clk.
REQ-028 After rst_n rises, the first accepted sample SHALL be treated as a window start.
REQ-029 Reset asserted mid-window SHALL discard the partial window; no done pulse SHALL be issued.

Verification
REQ-030 Scenario, window of 4:
- Stimulus: win_sel=01; samples 0x10, 0x80, 0x7F, 0x05.
- Response: done pulses once after the 4th sample; uo_out=0x80; new_peak pulses after samples 1 and 2 only; busy=0 afterwards.
REQ-031 Scenario, ties and unsigned compare in free-running mode:
- Stimulus: win_sel=00; samples 0xFF, 0x00, 0xFF.
- Response: uo_out=0xFF from the first sample on; new_peak pulses only after the first sample; done is never asserted.
REQ-032 Scenario, clear priority:
- Stimulus: clear=1 and sample_valid=1 with ui_in=0xAA in the same cycle, while in TRACK.
- Response: next cycle uo_out=0x00, busy=0, and no new_peak.
REQ-033 Scenario, win_sel change mid-window:
- Stimulus: start with win_sel=01; switch to 11 after 2 samples.
- Response: the window still completes after 4 samples; the next window then lasts 64 samples, with done after the 64th.
REQ-034 Scenario, async reset mid-window:
- Stimulus: win_sel=10; 7 samples including 0x9C; rst_n=0 pulsed between clk edges.
- Response: uo_out=0x00 and busy=0 without any clk edge; no done pulse.
REQ-035 Scenario, gapped valid:
- Stimulus: win_sel=01; 4 samples with idle gaps of 0–3 cycles between them.
- Response: done is issued exactly once, after the 4th accepted sample; uo_out holds between windows.

Source files
------------

// File: rtl/tt_um_peak_tracker.sv
// Windowed peak tracker: follows the running maximum of an unsigned sample
// stream. It reports either a free-running peak or the peak of each
// fixed-length window (4, 16 or 64 accepted samples).
module tt_um_peak_tracker #(
    parameter int unsigned W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic {StIdle, StTrack} state_e;

    logic           sample_valid;
    logic           clear;
    logic [1:0]     win_sel;
    logic [W-1:0]   sample;

    assign sample_valid = uio_in[0];
    assign clear        = uio_in[1];
    assign win_sel      = uio_in[3:2];
    assign sample       = ui_in[W-1:0];

    // ena and the upper bidirectional inputs carry no function
    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in[7:4]};

    logic [1:0] rst_sync_q;
    logic       rst_sync_n;

    state_e       state_q, state_d;
    logic [W-1:0] run_peak_q, run_peak_d;
    logic [W-1:0] result_q, result_d;
    logic [6:0]   count_q, count_d;
    logic [1:0]   win_lat_q, win_lat_d;
    logic         done_q, done_d;
    logic         new_peak_q, new_peak_d;

    logic [6:0]   win_len;
    logic [6:0]   count_inc;
    logic         above;
    logic [W-1:0] peak_max;

    // Reset asserts immediately but releases only after two clock edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_sync_n = rst_sync_q[1];

    // Window length decoded from the latched selection; 0 means free-running
    always_comb begin
        win_len = 7'd0;
        unique case (win_lat_q)
            2'b01:   win_len = 7'd4;
            2'b10:   win_len = 7'd16;
            2'b11:   win_len = 7'd64;
            default: win_len = 7'd0;
        endcase
    end

    assign count_inc = count_q + 7'd1;
    assign above     = (sample > run_peak_q);
    assign peak_max  = above ? sample : run_peak_q;

    // Next-state: clear beats a sample; pulses default low every cycle
    always_comb begin
        state_d    = state_q;
        run_peak_d = run_peak_q;
        result_d   = result_q;
        count_d    = count_q;
        win_lat_d  = win_lat_q;
        done_d     = 1'b0;
        new_peak_d = 1'b0;

        if (clear) begin
            state_d    = StIdle;
            run_peak_d = '0;
            result_d   = '0;
            count_d    = 7'd0;
        end else if (sample_valid) begin
            unique case (state_q)
                StIdle: begin
                    state_d    = StTrack;
                    run_peak_d = sample;
                    count_d    = 7'd1;
                    win_lat_d  = win_sel;
                    new_peak_d = 1'b1;
                end
                StTrack: begin
                    run_peak_d = peak_max;
                    new_peak_d = above;
                    if (win_lat_q == 2'b00) begin
                        // Free-running: count saturates, never completes
                        count_d = (count_q >= 7'd63) ? 7'd63 : count_inc;
                    end else if (count_inc == win_len) begin
                        result_d = peak_max;
                        done_d   = 1'b1;
                        count_d  = 7'd0;
                        state_d  = StIdle;
                    end else begin
                        count_d = count_inc;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and result registers
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q    <= StIdle;
            run_peak_q <= '0;
            result_q   <= '0;
            count_q    <= 7'd0;
            win_lat_q  <= 2'b00;
            done_q     <= 1'b0;
            new_peak_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_peak_q <= run_peak_d;
            result_q   <= result_d;
            count_q    <= count_d;
            win_lat_q  <= win_lat_d;
            done_q     <= done_d;
            new_peak_q <= new_peak_d;
        end
    end

    // Outputs decode registered state only; no input reaches them directly
    always_comb begin
        uo_out = result_q;
        if (state_q == StTrack && win_lat_q == 2'b00) begin
            uo_out = run_peak_q;
        end
        uio_out = {1'b0, (state_q == StTrack), new_peak_q, done_q, 4'b0000};
        uio_oe  = 8'hF0;
    end

endmodule

// File: tb/tb_tt_um_peak_tracker.sv
// Directed bench for the peak tracker: each task drives one scenario and
// checks the registered outputs one time unit after the clock edge.
module tb_tt_um_peak_tracker;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int tests_run;
    int tests_failed;

    logic done, new_peak, busy;
    assign done     = uio_out[4];
    assign new_peak = uio_out[5];
    assign busy     = uio_out[6];

    tt_um_peak_tracker #(.W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then settle just past the next rising edge
    task automatic step(input logic v, input logic c, input logic [1:0] w,
                        input logic [7:0] d);
        ui_in  = d;
        uio_in = {4'b0000, w, c, v};
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ena   = 1'b1;
        ui_in = 8'h00;
        uio_in = 8'h00;
        #2;
        tests_run++;
        if (uo_out !== 8'h00) begin
            tests_failed++; $display("FAIL reset_uo_out got %h want 00", uo_out);
        end
        tests_run++;
        if (uio_out !== 8'h00) begin
            tests_failed++; $display("FAIL reset_uio_out got %h want 00", uio_out);
        end
        tests_run++;
        if (uio_oe !== 8'hF0) begin
            tests_failed++; $display("FAIL reset_uio_oe got %h want f0", uio_oe);
        end
        step(1'b0, 1'b0, 2'b00, 8'h00);
        step(1'b0, 1'b0, 2'b00, 8'h00);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'b00, 8'h00);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++; $display("FAIL reset_busy got %b want 0", busy);
        end
    endtask

    task automatic test_window4();
        logic [7:0] data [4]  = '{8'h10, 8'h80, 8'h7F, 8'h05};
        logic       np_e [4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic       dn_e [4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic       bz_e [4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 2'b01, data[i]);
            tests_run++;
            if (new_peak !== np_e[i] || done !== dn_e[i] || busy !== bz_e[i]) begin
                tests_failed++;
                $display("FAIL win4_flags[%0d] got np=%b done=%b busy=%b want np=%b done=%b busy=%b",
                         i, new_peak, done, busy, np_e[i], dn_e[i], bz_e[i]);
            end
        end
        tests_run++;
        if (uo_out !== 8'h80) begin
            tests_failed++; $display("FAIL win4_peak got %h want 80", uo_out);
        end
        step(1'b0, 1'b0, 2'b01, 8'h00);
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0 || uo_out !== 8'h80) begin
            tests_failed++;
            $display("FAIL win4_after got done=%b busy=%b uo=%h want 0 0 80", done, busy, uo_out);
        end
    endtask

    task automatic test_free_run();
        logic [7:0] data [3] = '{8'hFF, 8'h00, 8'hFF};
        logic       np_e [3] = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 2'b00, data[i]);
            tests_run++;
            if (uo_out !== 8'hFF || new_peak !== np_e[i] || done !== 1'b0) begin
                tests_failed++;
                $display("FAIL free_run[%0d] got uo=%h np=%b done=%b want ff %b 0",
                         i, uo_out, new_peak, done, np_e[i]);
            end
        end
        // Long run past the count saturation point: never completes
        for (int i = 0; i < 70; i++) begin
            step(1'b1, 1'b0, 2'b01, 8'h00);
            tests_run++;
            if (done !== 1'b0 || busy !== 1'b1 || uo_out !== 8'hFF) begin
                tests_failed++;
                $display("FAIL free_run_long[%0d] got done=%b busy=%b uo=%h want 0 1 ff",
                         i, done, busy, uo_out);
            end
        end
    endtask

    task automatic test_clear();
        step(1'b1, 1'b1, 2'b00, 8'hAA);
        tests_run++;
        if (uo_out !== 8'h00 || busy !== 1'b0 || new_peak !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear got uo=%h busy=%b np=%b done=%b want 00 0 0 0",
                     uo_out, busy, new_peak, done);
        end
    endtask

    task automatic test_win_change();
        int dones;
        step(1'b1, 1'b0, 2'b01, 8'h01);
        step(1'b1, 1'b0, 2'b01, 8'h02);
        step(1'b1, 1'b0, 2'b11, 8'h03);
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++; $display("FAIL winchg_3rd got done=%b want 0", done);
        end
        step(1'b1, 1'b0, 2'b11, 8'h04);
        tests_run++;
        if (done !== 1'b1 || uo_out !== 8'h04) begin
            tests_failed++;
            $display("FAIL winchg_first got done=%b uo=%h want 1 04", done, uo_out);
        end
        dones = 0;
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 1'b0, (i < 10) ? 2'b11 : 2'b01,
                 (i == 40) ? 8'hC3 : 8'(i));
            if (done === 1'b1) dones++;
            if (i == 62) begin
                tests_run++;
                if (done !== 1'b0 || busy !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL winchg_63rd got done=%b busy=%b want 0 1", done, busy);
                end
            end
        end
        tests_run++;
        if (done !== 1'b1 || uo_out !== 8'hC3 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL winchg_64th got done=%b uo=%h busy=%b want 1 c3 0", done, uo_out, busy);
        end
        tests_run++;
        if (dones != 1) begin
            tests_failed++; $display("FAIL winchg_done_count got %0d want 1", dones);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] data [7] = '{8'h11, 8'h9C, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        int dones;
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 2'b10, data[i]);
        tests_run++;
        if (busy !== 1'b1 || uo_out !== 8'hC3) begin
            tests_failed++;
            $display("FAIL arst_pre got busy=%b uo=%h want 1 c3", busy, uo_out);
        end
        uio_in = 8'h00;
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (uo_out !== 8'h00 || busy !== 1'b0 || uio_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL arst_now got uo=%h busy=%b uio=%h want 00 0 00", uo_out, busy, uio_out);
        end
        #3;
        rst_n = 1'b1;
        // First edge after release: reset still held internally, sample ignored
        step(1'b1, 1'b0, 2'b10, 8'h77);
        tests_run++;
        if (busy !== 1'b0 || new_peak !== 1'b0) begin
            tests_failed++;
            $display("FAIL arst_sync got busy=%b np=%b want 0 0", busy, new_peak);
        end
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 2'b10, 8'h00);
            if (done !== 1'b0) dones++;
        end
        tests_run++;
        if (dones != 0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL arst_no_done got dones=%0d busy=%b want 0 0", dones, busy);
        end
    endtask

    task automatic test_post_reset();
        step(1'b1, 1'b0, 2'b01, 8'h20);
        tests_run++;
        if (new_peak !== 1'b1 || busy !== 1'b1 || uo_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL post_first got np=%b busy=%b uo=%h want 1 1 00", new_peak, busy, uo_out);
        end
        step(1'b1, 1'b0, 2'b01, 8'h30);
        step(1'b1, 1'b0, 2'b01, 8'h10);
        step(1'b1, 1'b0, 2'b01, 8'h40);
        tests_run++;
        if (done !== 1'b1 || uo_out !== 8'h40) begin
            tests_failed++;
            $display("FAIL post_done got done=%b uo=%h want 1 40", done, uo_out);
        end
    endtask

    task automatic test_gapped();
        logic [7:0] data [4] = '{8'h05, 8'h09, 8'h03, 8'h07};
        int dones;
        int bad_gap;
        dones = 0;
        bad_gap = 0;
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < i; g++) begin
                step(1'b0, 1'b0, 2'b01, 8'hEE);
                if (done !== 1'b0 || new_peak !== 1'b0 || uo_out !== 8'h40) bad_gap++;
            end
            step(1'b1, 1'b0, 2'b01, data[i]);
            if (done === 1'b1) dones++;
        end
        tests_run++;
        if (bad_gap != 0) begin
            tests_failed++; $display("FAIL gap_hold got %0d bad cycles want 0", bad_gap);
        end
        tests_run++;
        if (dones != 1 || done !== 1'b1 || uo_out !== 8'h09) begin
            tests_failed++;
            $display("FAIL gap_done got dones=%0d done=%b uo=%h want 1 1 09", dones, done, uo_out);
        end
        step(1'b0, 1'b0, 2'b01, 8'h00);
        tests_run++;
        if (done !== 1'b0 || uo_out !== 8'h09) begin
            tests_failed++;
            $display("FAIL gap_after got done=%b uo=%h want 0 09", done, uo_out);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_window4();
        test_free_run();
        test_clear();
        test_win_change();
        test_async_reset();
        test_post_reset();
        test_gapped();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
